// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : opcode constants, decoded instruction type, issue-stage types
// Revision  : 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  reg_A;
    logic [4:0]  reg_B;
    logic [11:0] imm;
    logic [31:0] imm_extended;
    logic [31:0] pc;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } issue_state_e;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR) ||
           (opcode == OPCODE_BRANCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if : decoder-side and ALU-side handshakes of the issue stage
// Revision          : 1.0
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
  import riscv_pkg::*;

  logic           dec_valid;
  decoded_instr_t dec_instr;
  logic           dec_ready;
  logic           alu_valid;
  decoded_instr_t alu_instr;
  logic           mem_ready;

  // master is the issue controller; slave is the decoder/ALU environment
  modport master (
    input  dec_valid, dec_instr, mem_ready,
    output dec_ready, alu_valid, alu_instr
  );

  modport slave (
    output dec_valid, dec_instr, mem_ready,
    input  dec_ready, alu_valid, alu_instr
  );

endinterface
`default_nettype wire

// File: rtl/issue_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_skid_buf : output register plus one-entry skid register
// Revision       : 1.0
// ---------------------------------------------------------------------------
module issue_skid_buf
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_out,
  input  logic           load_skid,
  input  logic           move_skid,
  input  decoded_instr_t din,
  output decoded_instr_t out_instr
);

  decoded_instr_t out_q, out_d;
  decoded_instr_t skid_q, skid_d;

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    // draining the skid entry takes precedence so FIFO order is kept
    if (move_skid) begin
      out_d = skid_q;
    end else if (load_out) begin
      out_d = din;
    end
    if (load_skid) begin
      skid_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign out_instr = out_q;

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_issue_ctrl : decode->execute issue controller with skid buffer,
//                  shadow squash, flush and stall/squash counters
// Revision       : 1.0
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int SHADOW = 2,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_ctrl_if.master    bus,
  input  logic                flush,
  output logic                squash_active,
  output logic [CW-1:0]       stall_cnt,
  output logic [CW-1:0]       squash_cnt
);

  localparam int              SHW      = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
  localparam logic [SHW-1:0]  SH_LOAD  = SHW'(SHADOW);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  issue_state_e   state_q, state_d;
  logic           dec_ready_q, dec_ready_d;
  logic [SHW-1:0] sh_cnt_q, sh_cnt_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]  squash_cnt_q, squash_cnt_d;

  logic           alu_valid;
  logic           handshake;
  logic           accept;
  logic           squash;
  logic           xfer;
  logic           load_out;
  logic           load_skid;
  logic           move_skid;
  decoded_instr_t out_instr;

  assign alu_valid = (state_q != EMPTY);
  assign handshake = bus.dec_valid & dec_ready_q & ~flush;
  assign accept    = handshake & (sh_cnt_q == '0);
  assign squash    = handshake & (sh_cnt_q != '0);
  assign xfer      = alu_valid & bus.mem_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // a flush empties the stage; any xfer this cycle has already been taken
    if (flush) begin
      state_d   = EMPTY;
      move_skid = 1'b0;
    end
    dec_ready_d = (state_d != FULL);
  end

  always_comb begin
    sh_cnt_d = sh_cnt_q;
    if (flush) begin
      sh_cnt_d = '0;
    end else if (accept && is_ctrl_flow(bus.dec_instr.opcode)) begin
      sh_cnt_d = SH_LOAD;
    end else if (squash) begin
      sh_cnt_d = sh_cnt_q - SHW'(1);
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (alu_valid && !bus.mem_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
    if (squash && (squash_cnt_q != CNT_MAX)) begin
      squash_cnt_d = squash_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      dec_ready_q  <= 1'b0;
      sh_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      dec_ready_q  <= dec_ready_d;
      sh_cnt_q     <= sh_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  issue_skid_buf u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_out  (load_out),
    .load_skid (load_skid),
    .move_skid (move_skid),
    .din       (bus.dec_instr),
    .out_instr (out_instr)
  );

  assign bus.dec_ready = dec_ready_q;
  assign bus.alu_valid = alu_valid;
  assign bus.alu_instr = out_instr;
  assign squash_active = (sh_cnt_q != '0);
  assign stall_cnt     = stall_cnt_q;
  assign squash_cnt    = squash_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl : directed table, corner sequences and random stimulus
//                     against a queue-based reference model
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  import riscv_pkg::*;

  localparam int SHADOW = 2;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          squash_active;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] squash_cnt;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.SHADOW(SHADOW), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flush         (flush),
    .squash_active (squash_active),
    .stall_cnt     (stall_cnt),
    .squash_cnt    (squash_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: held instructions as a FIFO of at most two entries
  decoded_instr_t mq[$];
  logic           m_rdy;
  int             m_sh, m_stall, m_sq;
  decoded_instr_t issued[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input logic [6:0] op, input int tag);
    decoded_instr_t d;
    logic [31:0] t;
    t              = tag;
    d.opcode       = op;
    d.funct3       = t[2:0];
    d.funct7       = t[9:3];
    d.reg_A        = t[4:0];
    d.reg_B        = t[9:5];
    d.imm          = t[11:0];
    d.imm_extended = {t[15:0], ~t[15:0]};
    d.pc           = 32'h1000 + (t << 2);
    return d;
  endfunction

  function automatic bit ctrl_op(input logic [6:0] op);
    return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy   = 1'b0;
    m_sh    = 0;
    m_stall = 0;
    m_sq    = 0;
  endtask

  task automatic model_step(input logic v, input decoded_instr_t ins, input logic mr, input logic fl);
    bit held, hs;
    held = (mq.size() != 0);
    hs   = v && m_rdy && !fl;
    if (held && !mr && m_stall < CMAX) m_stall++;
    if (hs && m_sh != 0 && m_sq < CMAX) m_sq++;
    if (held && mr) void'(mq.pop_front());
    if (fl) begin
      mq.delete();
      m_sh = 0;
    end else if (hs && m_sh == 0) begin
      mq.push_back(ins);
      if (ctrl_op(ins.opcode)) m_sh = SHADOW;
    end else if (hs) begin
      m_sh--;
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic model_check();
    chk("alu_valid", bus.alu_valid, mq.size() != 0);
    if (mq.size() != 0) chk("alu_instr", bus.alu_instr, mq[0]);
    chk("dec_ready", bus.dec_ready, m_rdy);
    chk("squash_active", squash_active, m_sh != 0);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("squash_cnt", squash_cnt, m_sq);
  endtask

  task automatic cycle(input logic v, input decoded_instr_t ins, input logic mr, input logic fl);
    bus.dec_valid = v;
    bus.dec_instr = ins;
    bus.mem_ready = mr;
    flush         = fl;
    if (bus.alu_valid && mr) issued.push_back(bus.alu_instr);
    model_step(v, ins, mr, fl);
    @(posedge clk);
    #1;
    model_check();
  endtask

  // asynchronous reset applied between clock edges
  task automatic do_reset();
    #2;
    bus.dec_valid = 1'b0;
    bus.mem_ready = 1'b0;
    flush         = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("rst.alu_valid", bus.alu_valid, 1'b0);
    chk("rst.dec_ready", bus.dec_ready, 1'b0);
    chk("rst.squash_active", squash_active, 1'b0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.squash_cnt", squash_cnt, 0);
    chk("rst.alu_instr", bus.alu_instr, 0);
    model_reset();
    issued.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic           v;
    decoded_instr_t ins;
    logic           mr;
    logic           fl;
    logic           e_valid;
    decoded_instr_t e_instr;
    logic           e_rdy;
    logic           e_sa;
    int             e_stall;
    int             e_sq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input decoded_instr_t ins, input logic mr, input logic fl,
                     input logic ev, input decoded_instr_t ei, input logic er, input logic esa,
                     input int est, input int esq);
    vec_t r;
    r.v = v; r.ins = ins; r.mr = mr; r.fl = fl;
    r.e_valid = ev; r.e_instr = ei; r.e_rdy = er; r.e_sa = esa;
    r.e_stall = est; r.e_sq = esq;
    tbl.push_back(r);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    decoded_instr_t Z, A1, A2, A3, A4, B1, B2, B3, BR, C1, C2, C3;
    decoded_instr_t D1, D2, D3, E1, E2, J, F1, F2;
    decoded_instr_t exp_iss[$];

    Z  = '0;
    A1 = mk(OPCODE_OP, 1);   A2 = mk(OPCODE_OP, 2);   A3 = mk(OPCODE_OP, 3);
    A4 = mk(OPCODE_OP, 4);   B1 = mk(OPCODE_OP, 11);  B2 = mk(OPCODE_OP, 12);
    B3 = mk(OPCODE_OP, 13);  BR = mk(OPCODE_BRANCH, 20);
    C1 = mk(OPCODE_OP, 21);  C2 = mk(OPCODE_OP, 22);  C3 = mk(OPCODE_OP, 23);
    D1 = mk(OPCODE_OP, 31);  D2 = mk(OPCODE_OP, 32);  D3 = mk(OPCODE_OP, 33);
    E1 = mk(OPCODE_OP, 41);  E2 = mk(OPCODE_OP, 42);  J  = mk(OPCODE_JAL, 50);
    F1 = mk(OPCODE_OP, 51);  F2 = mk(OPCODE_OP, 52);

    //   v  ins mr fl | valid instr rdy sa stall sq
    add(0, Z,  1, 0,  0, Z,  1, 0, 0, 0);
    add(1, A1, 1, 0,  1, A1, 1, 0, 0, 0);
    add(1, A2, 1, 0,  1, A2, 1, 0, 0, 0);
    add(1, A3, 1, 0,  1, A3, 1, 0, 0, 0);
    add(1, A4, 1, 0,  1, A4, 1, 0, 0, 0);
    add(0, Z,  1, 0,  0, Z,  1, 0, 0, 0);
    add(1, B1, 0, 0,  1, B1, 1, 0, 0, 0);
    add(1, B2, 0, 0,  1, B1, 0, 0, 1, 0);
    add(1, B3, 0, 0,  1, B1, 0, 0, 2, 0);
    add(1, B3, 0, 0,  1, B1, 0, 0, 3, 0);
    add(1, B3, 1, 0,  1, B2, 1, 0, 3, 0);
    add(1, B3, 1, 0,  1, B3, 1, 0, 3, 0);
    add(0, Z,  1, 0,  0, Z,  1, 0, 3, 0);
    add(1, BR, 1, 0,  1, BR, 1, 1, 3, 0);
    add(1, C1, 1, 0,  0, Z,  1, 1, 3, 1);
    add(1, C2, 1, 0,  0, Z,  1, 0, 3, 2);
    add(1, C3, 1, 0,  1, C3, 1, 0, 3, 2);
    add(0, Z,  1, 0,  0, Z,  1, 0, 3, 2);
    add(1, D1, 0, 0,  1, D1, 1, 0, 3, 2);
    add(1, D2, 0, 0,  1, D1, 0, 0, 4, 2);
    add(1, D3, 0, 1,  0, Z,  1, 0, 5, 2);
    add(0, Z,  1, 0,  0, Z,  1, 0, 5, 2);
    add(1, E1, 1, 0,  1, E1, 1, 0, 5, 2);
    add(1, E2, 1, 1,  0, Z,  1, 0, 5, 2);
    add(0, Z,  1, 0,  0, Z,  1, 0, 5, 2);
    add(1, J,  1, 0,  1, J,  1, 1, 5, 2);
    add(1, F1, 0, 1,  0, Z,  1, 0, 6, 2);
    add(1, F2, 1, 0,  1, F2, 1, 0, 6, 2);
    add(0, Z,  1, 0,  0, Z,  1, 0, 6, 2);

    bus.dec_valid = 1'b0;
    bus.dec_instr = '0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].ins, tbl[i].mr, tbl[i].fl);
      chk($sformatf("tbl[%0d].alu_valid", i), bus.alu_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl[%0d].alu_instr", i), bus.alu_instr, tbl[i].e_instr);
      chk($sformatf("tbl[%0d].dec_ready", i), bus.dec_ready, tbl[i].e_rdy);
      chk($sformatf("tbl[%0d].squash_active", i), squash_active, tbl[i].e_sa);
      chk($sformatf("tbl[%0d].stall_cnt", i), stall_cnt, tbl[i].e_stall);
      chk($sformatf("tbl[%0d].squash_cnt", i), squash_cnt, tbl[i].e_sq);
    end

    exp_iss = '{A1, A2, A3, A4, B1, B2, B3, BR, C3, E1, F2};
    chk("issued.count", issued.size(), exp_iss.size());
    foreach (exp_iss[i]) begin
      if (i < issued.size()) chk($sformatf("issued[%0d]", i), issued[i], exp_iss[i]);
    end

    // counter saturation under a long stall, then asynchronous reset mid-stall
    do_reset();
    cycle(0, Z, 0, 0);
    cycle(1, BR, 0, 0);
    cycle(1, C1, 0, 0);
    cycle(1, C2, 0, 0);
    repeat (20) cycle(0, Z, 0, 0);
    chk("sat.stall_cnt", stall_cnt, CMAX);
    chk("sat.squash_cnt", squash_cnt, 2);
    chk("sat.alu_instr", bus.alu_instr, BR);
    do_reset();

    // randomized traffic with periodic asynchronous resets
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      if (i % 150 == 149) do_reset();
      case ($urandom_range(0, 9))
        0: op = OPCODE_BRANCH;
        1: op = OPCODE_JAL;
        2: op = OPCODE_JALR;
        3: op = OPCODE_LOAD;
        4: op = OPCODE_OP_IMM;
        default: op = OPCODE_OP;
      endcase
      cycle($urandom_range(0, 3) != 0, mk(op, $urandom_range(0, 4095)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
